// File: rtl/registerfile_sb_if.sv
// Register file bus: writeback, two read ports, issue marking and the Clear control.
interface registerfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            Load;
    logic [AW-1:0]   addrD;
    logic [XLEN-1:0] D;
    logic [AW-1:0]   addrA;
    logic [AW-1:0]   addrB;
    logic [XLEN-1:0] dataA;
    logic [XLEN-1:0] dataB;
    logic            Issue;
    logic [AW-1:0]   addrI;
    logic            busyA;
    logic            busyB;
    logic            Clear;
    logic            ClearBusy;

    modport master (
        output Load, addrD, D, addrA, addrB, Issue, addrI, Clear,
        input  dataA, dataB, busyA, busyB, ClearBusy
    );

    modport slave (
        input  Load, addrD, D, addrA, addrB, Issue, addrI, Clear,
        output dataA, dataB, busyA, busyB, ClearBusy
    );
endinterface

// File: rtl/registerfile_sb.sv
// 2-read/1-write register file with pending scoreboard and sequential Clear engine.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | normal operation: writes, issues, bypass enabled
//   CLEAR | zero-filling entry clr_cnt each cycle; Load/Issue/Clear ignored
module registerfile_sb #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic               Clk,
    input logic               Reset_n,
    registerfile_sb_if.slave  bus
);
    localparam int NREG = 2**AW;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state;
    logic            clear_busy_q;
    logic [AW-1:0]   clr_cnt;
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pending;

    logic            wr_en;
    logic            iss_en;
    logic            byp_a;
    logic            byp_b;
    logic [XLEN-1:0] data_a;
    logic [XLEN-1:0] data_b;
    logic            busy_a;
    logic            busy_b;

    // Register 0 swallows writes and issues when it is hardwired to zero.
    assign wr_en  = (state == IDLE) && bus.Load &&
                    !((ZERO_REG != 0) && (bus.addrD == '0));
    assign iss_en = (state == IDLE) && bus.Issue &&
                    !((ZERO_REG != 0) && (bus.addrI == '0));

    // Clear sequencer; ClearBusy is registered alongside the state so it tracks CLEAR exactly.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            clr_cnt      <= '0;
            clear_busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Clear) begin
                        state        <= CLEAR;
                        clr_cnt      <= '0;
                        clear_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == AW'(NREG - 1)) begin
                        state        <= IDLE;
                        clear_busy_q <= 1'b0;
                    end
                    clr_cnt <= clr_cnt + AW'(1);
                end
                default: begin
                    state        <= IDLE;
                    clear_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Data array: writeback in IDLE, one entry zeroed per cycle in CLEAR.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[clr_cnt] <= '0;
        end else if (wr_en) begin
            regs[bus.addrD] <= bus.D;
        end
    end

    // Scoreboard: writeback retires a pending bit, issue sets one; the set is
    // applied last so a same-cycle issue to the written address stays pending.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pending <= '0;
        end else if (state == CLEAR) begin
            pending[clr_cnt] <= 1'b0;
        end else begin
            if (wr_en) begin
                pending[bus.addrD] <= 1'b0;
            end
            if (iss_en) begin
                pending[bus.addrI] <= 1'b1;
            end
        end
    end

    // Read ports: zero register first, then same-cycle forwarding, then the array.
    always_comb begin
        byp_a  = (BYPASS != 0) && (state == IDLE) && bus.Load && (bus.addrD == bus.addrA);
        byp_b  = (BYPASS != 0) && (state == IDLE) && bus.Load && (bus.addrD == bus.addrB);
        data_a = regs[bus.addrA];
        busy_a = pending[bus.addrA];
        data_b = regs[bus.addrB];
        busy_b = pending[bus.addrB];
        if ((ZERO_REG != 0) && (bus.addrA == '0)) begin
            data_a = '0;
            busy_a = 1'b0;
        end else if (byp_a) begin
            data_a = bus.D;
            busy_a = 1'b0;
        end
        if ((ZERO_REG != 0) && (bus.addrB == '0)) begin
            data_b = '0;
            busy_b = 1'b0;
        end else if (byp_b) begin
            data_b = bus.D;
            busy_b = 1'b0;
        end
    end

    assign bus.dataA     = data_a;
    assign bus.dataB     = data_b;
    assign bus.busyA     = busy_a;
    assign bus.busyB     = busy_b;
    assign bus.ClearBusy = clear_busy_q;

endmodule

// File: tb/tb_registerfile_sb.sv
// Bench for registerfile_sb: one DUT with bypass, one without, both driven identically
// and checked every cycle against an array/scoreboard model plus directed literals.
module tb_registerfile_sb;
    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        load, issue, clear;
    logic [4:0]  addr_d, addr_a, addr_b, addr_i;
    logic [31:0] d;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [31:0] m_reg  [32];
    bit          m_pend [32];
    bit          m_clr;
    int          m_idx;

    always #5 Clk = ~Clk;

    registerfile_sb_if #(.XLEN(32), .AW(5)) ifa ();
    registerfile_sb_if #(.XLEN(32), .AW(5)) ifb ();

    assign ifa.Load  = load;   assign ifb.Load  = load;
    assign ifa.addrD = addr_d; assign ifb.addrD = addr_d;
    assign ifa.D     = d;      assign ifb.D     = d;
    assign ifa.addrA = addr_a; assign ifb.addrA = addr_a;
    assign ifa.addrB = addr_b; assign ifb.addrB = addr_b;
    assign ifa.Issue = issue;  assign ifb.Issue = issue;
    assign ifa.addrI = addr_i; assign ifb.addrI = addr_i;
    assign ifa.Clear = clear;  assign ifb.Clear = clear;

    registerfile_sb #(.XLEN(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) dut_byp (
        .Clk(Clk), .Reset_n(Reset_n), .bus(ifa.slave));
    registerfile_sb #(.XLEN(32), .AW(5), .ZERO_REG(1), .BYPASS(0)) dut_nob (
        .Clk(Clk), .Reset_n(Reset_n), .bus(ifb.slave));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Model: the architectural register file, pending set and a Clear sweep position.
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  = '0;
                m_pend[i] = 1'b0;
            end
            m_clr = 1'b0;
            m_idx = 0;
        end else if (m_clr) begin
            m_reg[m_idx]  = '0;
            m_pend[m_idx] = 1'b0;
            if (m_idx == 31) m_clr = 1'b0;
            else m_idx = m_idx + 1;
        end else begin
            if (load && addr_d != 0) begin
                m_reg[addr_d]  = d;
                m_pend[addr_d] = 1'b0;
            end
            if (issue && addr_i != 0) m_pend[addr_i] = 1'b1;
            if (clear) begin
                m_clr = 1'b1;
                m_idx = 0;
            end
        end
    end

    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && !m_clr && load && addr_d == a) return d;
        return m_reg[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && !m_clr && load && addr_d == a) return '0;
        return {31'b0, m_pend[a]};
    endfunction

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge Clk) begin
        chk("byp_dataA", ifa.dataA, exp_data(addr_a, 1'b1));
        chk("byp_dataB", ifa.dataB, exp_data(addr_b, 1'b1));
        chk("byp_busyA", {31'b0, ifa.busyA}, exp_busy(addr_a, 1'b1));
        chk("byp_busyB", {31'b0, ifa.busyB}, exp_busy(addr_b, 1'b1));
        chk("byp_clrbusy", {31'b0, ifa.ClearBusy}, {31'b0, m_clr});
        chk("nob_dataA", ifb.dataA, exp_data(addr_a, 1'b0));
        chk("nob_dataB", ifb.dataB, exp_data(addr_b, 1'b0));
        chk("nob_busyA", {31'b0, ifb.busyA}, exp_busy(addr_a, 1'b0));
        chk("nob_busyB", {31'b0, ifb.busyB}, exp_busy(addr_b, 1'b0));
        chk("nob_clrbusy", {31'b0, ifb.ClearBusy}, {31'b0, m_clr});
    end

    initial begin
        int n;
        Reset_n = 1'b0;
        load = 0; issue = 0; clear = 0;
        addr_d = 0; addr_i = 0; d = 0;
        addr_a = 5'd3; addr_b = 5'd31;
        tick(); tick();
        chk("rst_dataA", ifa.dataA, 32'h0);
        chk("rst_dataB", ifa.dataB, 32'h0);
        chk("rst_busyA", {31'b0, ifa.busyA}, 32'h0);
        chk("rst_clrbusy", {31'b0, ifa.ClearBusy}, 32'h0);
        Reset_n = 1'b1;
        tick();
        chk("post_rst_dataA", ifa.dataA, 32'h0);
        chk("post_rst_busyB", {31'b0, ifa.busyB}, 32'h0);

        // write with same-cycle read
        load = 1; addr_d = 5'd5; d = 32'hDEADBEEF; addr_a = 5'd5;
        #2;
        chk("bypass_hit", ifa.dataA, 32'hDEADBEEF);
        chk("nobypass_old", ifb.dataA, 32'h0);
        tick();
        load = 0;
        #2;
        chk("written_byp", ifa.dataA, 32'hDEADBEEF);
        chk("written_nob", ifb.dataA, 32'hDEADBEEF);

        // hardwired zero register
        tick();
        load = 1; addr_d = 5'd0; d = 32'h12345678; addr_a = 5'd0;
        tick();
        load = 0;
        #2;
        chk("zero_data", ifa.dataA, 32'h0);
        issue = 1; addr_i = 5'd0;
        tick();
        issue = 0;
        #2;
        chk("zero_busy", {31'b0, ifa.busyA}, 32'h0);

        // scoreboard
        issue = 1; addr_i = 5'd7; addr_a = 5'd7;
        tick();
        issue = 0;
        #2;
        chk("issued_busy", {31'b0, ifa.busyA}, 32'h1);
        tick();
        load = 1; addr_d = 5'd7; d = 32'h55;
        #2;
        chk("wb_byp_busy", {31'b0, ifa.busyA}, 32'h0);
        chk("wb_byp_data", ifa.dataA, 32'h55);
        chk("wb_nob_busy", {31'b0, ifb.busyA}, 32'h1);
        tick();
        load = 0;
        #2;
        chk("retired_busy", {31'b0, ifb.busyA}, 32'h0);

        // issue and load to the same address
        tick();
        issue = 1; load = 1; addr_i = 5'd9; addr_d = 5'd9; d = 32'h99; addr_b = 5'd9;
        tick();
        issue = 0; load = 0;
        #2;
        chk("same_data", ifb.dataB, 32'h99);
        chk("same_busy", {31'b0, ifa.busyB}, 32'h1);

        // Clear with preloaded contents
        tick();
        load = 1; addr_d = 5'd1; d = 32'hA; issue = 1; addr_i = 5'd4;
        tick();
        issue = 0; addr_d = 5'd31; d = 32'hB;
        tick();
        load = 0; addr_a = 5'd1; addr_b = 5'd31;
        #2;
        chk("pre_clr_r1", ifa.dataA, 32'hA);
        chk("pre_clr_r31", ifa.dataB, 32'hB);
        tick();
        clear = 1; addr_a = 5'd2; addr_b = 5'd4;
        tick();
        clear = 0;
        n = 0;
        while (ifa.ClearBusy && n < 40) begin
            if (n == 3) begin load = 1; addr_d = 5'd2; d = 32'hFF; end
            if (n == 4) load = 0;
            if (n == 5) clear = 1;
            if (n == 6) clear = 0;
            n++;
            tick();
        end
        chk("clear_cycles", n, 32);
        for (int a = 0; a < 32; a++) begin
            addr_a = 5'(a); addr_b = 5'(31 - a);
            #2;
            chk("post_clr_data", ifa.dataA, 32'h0);
            chk("post_clr_busy", {31'b0, ifa.busyB}, 32'h0);
            tick();
        end

        // reset in the middle of a Clear
        load = 1; addr_d = 5'd10; d = 32'h1010; issue = 1; addr_i = 5'd11;
        tick();
        load = 0; issue = 0; clear = 1;
        tick();
        clear = 0; addr_a = 5'd10; addr_b = 5'd11;
        for (int i = 0; i < 9; i++) tick();
        #1;
        Reset_n = 1'b0;
        #1;
        chk("rst_mid_clrbusy", {31'b0, ifa.ClearBusy}, 32'h0);
        chk("rst_mid_data", ifa.dataA, 32'h0);
        chk("rst_mid_busy", {31'b0, ifa.busyB}, 32'h0);
        tick(); tick();
        Reset_n = 1'b1;
        tick();
        load = 1; addr_d = 5'd12; d = 32'hC0FFEE; addr_a = 5'd12;
        tick();
        load = 0;
        #2;
        chk("after_rst_write", ifb.dataA, 32'hC0FFEE);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/registerfile_sb.md
Name: registerfile_sb

Overview:
Parametrised successor to the core's 2-read/1-write register file. Width and depth are configurable. Adds:
- an optional hardwired-zero register 0;
- optional same-cycle write-to-read bypass;
- a per-register pending scoreboard for pipeline hazard detection;
- a multi-cycle sequential Clear engine.

It sits between the decode stage (reads, issue marking) and writeback (Load/D).

Parameters:
XLEN, 32, data width in bits
AW, 5, register address width; NREG = 2**AW registers
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/issues
BYPASS, 1, 1 = a same-cycle write is forwarded to read ports and masks the busy flags

Ports:
Clk  in  1  rising-edge clock
Reset_n  in  1  asynchronous, active-low reset
Load  in  1  write enable (writeback)
addrD  in  AW  write address
D  in  XLEN  write data
addrA  in  AW  read port A address
addrB  in  AW  read port B address
dataA  out  XLEN  read port A data (combinational)
dataB  out  XLEN  read port B data (combinational)
Issue  in  1  mark addrI as pending (instruction issued with this destination)
addrI  in  AW  destination being issued
busyA  out  1  pending flag for addrA
busyB  out  1  pending flag for addrB
Clear  in  1  start a sequential zero-fill of the array and scoreboard
ClearBusy  out  1  high while the Clear engine is active

Behaviour:
- Interface: one clock, Clk. Reset_n is asynchronous and active-low.
- Reset (Reset_n=0, asynchronous): all registers = 0, all pending bits = 0, FSM = IDLE, clear counter = 0.
- Output values after reset: dataA = dataB = 0, busyA = busyB = 0, ClearBusy = 0.
- Reset asserted mid-Clear aborts the Clear immediately.
- Write: at posedge, if FSM=IDLE and Load=1, then reg[addrD] <= D and pending[addrD] <= 0.
  - With ZERO_REG=1 and addrD=0, the write is dropped.
- Read: dataA/dataB are combinational from the array; the A path is described below and the B path is identical.
  - With ZERO_REG=1, addrA=0 gives dataA=0 and busyA=0.
  - With BYPASS=1, FSM=IDLE, Load=1, addrD=addrA (and addrA≠0 when ZERO_REG=1): dataA=D and busyA=0 in that same cycle.
  - Otherwise dataA=reg[addrA] and busyA=pending[addrA].
- Issue: at posedge, if FSM=IDLE and Issue=1, then pending[addrI] <= 1.
  - With ZERO_REG=1 and addrI=0, the issue is dropped.
  - Issue and Load to the same address in one cycle: the set wins, so the pending bit ends at 1 (a new producer exists). The data write still occurs.
- Clear FSM states:
  - IDLE: Clear=1 → CLEAR, counter <= 0. If Load/Issue are also asserted in that cycle, they are performed first.
  - CLEAR: each cycle reg[counter] <= 0, pending[counter] <= 0, counter++. When counter = NREG-1, write it, then → IDLE.
  - Total duration is exactly NREG cycles. ClearBusy=1 exactly while FSM=CLEAR.
- Behaviour while FSM=CLEAR:
  - Load and Issue are ignored (dropped, not queued).
  - Clear is ignored.
  - Bypass is disabled; reads return the current array contents, so already-cleared entries read 0.
  - busy flags reflect the current pending bits.
- Counter width is AW; it wraps naturally and is never observed beyond NREG-1.
- All array, pending and FSM updates occur on the rising edge of Clk only, apart from the asynchronous reset.

Test Plan:
- Reset: hold Reset_n=0 and drive addrA=3, addrB=31 → dataA=0, dataB=0, busyA=0, busyB=0, ClearBusy=0. Release reset → values unchanged.
- Write/read and bypass:
  - Load=1, addrD=5, D=0xDEADBEEF, addrA=5 in the same cycle → dataA=0xDEADBEEF combinationally (BYPASS=1).
  - Next cycle, Load=0 → dataA still 0xDEADBEEF.
  - Repeat with BYPASS=0 → dataA=0 during the write cycle, 0xDEADBEEF after.
- Zero register: Load=1, addrD=0, D=0x12345678, then addrA=0 → dataA=0. Issue addrI=0 → busyA=0 (ZERO_REG=1).
- Scoreboard:
  - Issue addrI=7 → next cycle busyA=1 for addrA=7.
  - Load addrD=7, D=0x55 with addrA=7 → busyA=0 that cycle (bypass); next cycle pending[7]=0.
  - Issue and Load both to addr 9 in the same cycle → data=D and busy stays 1 afterwards.
- Clear:
  - Preload reg[1]=0xA, reg[31]=0xB and pending[4]=1, then pulse Clear.
  - ClearBusy=1 for exactly 32 cycles.
  - A Load addrD=2, D=0xFF issued mid-Clear is dropped.
  - Afterwards all reads return 0 and all busy flags are 0.
- Reset mid-Clear: pulse Clear, assert Reset_n=0 at cycle 10 → ClearBusy=0 immediately and all registers read 0. After release, Load/read work normally.
